// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for the single write port of a
// synchronous FIFO. One producer at a time owns the port. It keeps the port for up
// to MAX_BURST accepted words, or until it drops its request. Between grants
// there is one arbitration (bubble) cycle.
//
// Handshake: a requester presents a word on its data_in slice with req[i]=1.
// The word is written at the rising edge where ack[i]=1. The requester must hold
// the word stable until then. Dropping req before ack abandons the word.
//
// Optional build macro FIFO_WR_ARB_STATS_EN adds a saturating count of stalled
// cycles: the owner is requesting while the FIFO is full. Without the macro,
// stall_cnt is tied to zero. Arbitration is identical in both builds.
`timescale 1ns/1ps

module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*DW-1:0] data_in,
    input  logic               fifo_full,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   ack,
    output logic               fifo_w_en,
    output logic [DW-1:0]      fifo_wdata,
    output logic               busy,
    output logic [15:0]        stall_cnt
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t             r_state, w_state_nxt;
    logic [IW-1:0]      r_owner, w_owner_nxt;
    logic [IW-1:0]      r_last, w_last_nxt;
    logic [CW-1:0]      r_count, w_count_nxt;
    logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic               r_busy;
    logic [IW-1:0]      w_winner;
    logic [N_REQ-1:0]   w_ack;
    logic               w_owner_req;

    // First set request bit strictly after 'last', wrapping modulo N_REQ.
    // The loop runs from the furthest candidate to the nearest one, so the
    // nearest set bit is the last one assigned.
    function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] last,
                                              input logic [N_REQ-1:0] r);
        logic [IW-1:0] pick;
        int            idx;
        pick = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            if (r[idx]) pick = IW'(idx);
        end
        return pick;
    endfunction

    // Round-robin winner, used only when leaving IDLE.
    always_comb begin
        w_winner = rr_pick(r_last, req);
    end

    assign w_owner_req = req[r_owner];

    // Only the current owner can be acked, and only while the FIFO has room.
    always_comb begin
        w_ack = '0;
        if (r_state == S_BURST && w_owner_req && !fifo_full)
            w_ack[r_owner] = 1'b1;
    end

    assign ack        = w_ack;
    assign fifo_w_en  = |w_ack;
    assign fifo_wdata = (r_state == S_BURST) ? data_in[int'(r_owner)*DW +: DW] : '0;
    assign gnt        = r_gnt;
    assign busy       = r_busy;

    // Next state: grant on any request in IDLE; release on a dropped request or a full burst.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_count_nxt = r_count;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt          = S_BURST;
                    w_owner_nxt          = w_winner;
                    w_count_nxt          = '0;
                    w_gnt_nxt            = '0;
                    w_gnt_nxt[w_winner]  = 1'b1;
                end
            end
            S_BURST: begin
                if (!w_owner_req || (fifo_w_en && r_count == CW'(MAX_BURST - 1))) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_owner;
                    w_count_nxt = '0;
                end else if (fifo_w_en) begin
                    w_count_nxt = r_count + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State, ownership and burst-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= IW'(N_REQ - 1);
            r_count <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_count <= w_count_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= (w_state_nxt == S_BURST);
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    // Count cycles where the owner wants to write but the FIFO is full; saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (r_state == S_BURST && w_owner_req && fifo_full && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench for fifo_wr_arbiter (N_REQ=4, DW=32,
// MAX_BURST=8). Each producer emits words {id[7:0], seq[23:0]}. The expected
// write order is derived from the round-robin burst rules and queued up front.
`timescale 1ns/1ps

module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DW        = 32;
    localparam int MAX_BURST = 8;
    localparam int FDEPTH    = 16;
`ifdef FIFO_WR_ARB_STATS_EN
    localparam int STALL_EXP = 5;
`else
    localparam int STALL_EXP = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_REQ-1:0]    req = '0;
    logic [N_REQ*DW-1:0] data_in = '0;
    logic                fifo_full = 1'b0;
    logic [N_REQ-1:0]    gnt, ack;
    logic                fifo_w_en;
    logic [DW-1:0]       fifo_wdata;
    logic                busy;
    logic [15:0]         stall_cnt;

    fifo_wr_arbiter #(.N_REQ(N_REQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .fifo_full(fifo_full),
        .gnt(gnt), .ack(ack), .fifo_w_en(fifo_w_en), .fifo_wdata(fifo_wdata),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mq[$];
    int n_checks = 0;
    int n_errors = 0;
    int rem[N_REQ];
    int seq[N_REQ];
    int mode = 0;        // 0: ignore writes, 1: check at write port, 2: FIFO model
    int n_wr = 0;
    int last_id = -1;
    int gap = 0;
    int stall_seen = 0;
    bit drain = 1'b0;
    logic [N_REQ-1:0] s_ack, s_gnt;
    logic             s_en, s_busy;
    logic [DW-1:0]    s_data;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input int r, input int s);
        logic [7:0]  rb;
        logic [23:0] sb;
        rb = r[7:0];
        sb = s[23:0];
        return {rb, sb};
    endfunction

    task automatic drive_req();
        for (int i = 0; i < N_REQ; i++) begin
            req[i] = (rem[i] > 0);
            data_in[i*DW +: DW] = mk_word(i, seq[i]);
        end
    endtask

    task automatic push_burst(input int r, input int first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(mk_word(r, first + k));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        fifo_full = 1'b0;
        mq.delete();
        drive_req();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_wr = 0;
        last_id = -1;
        gap = 0;
    endtask

    // One cycle: sample at the falling edge, then advance producers after the rising edge.
    task automatic step();
        logic          rd;
        logic [DW-1:0] e;
        logic [DW-1:0] got;
        int            id;
        @(negedge clk);
        s_ack = ack; s_en = fifo_w_en; s_data = fifo_wdata; s_gnt = gnt; s_busy = busy;
        rd = 1'b0;
        if (s_en) begin
            n_wr++;
            id = int'(s_data[31:24]);
            if (mode == 1) begin
                if (exp_q.size() == 0) begin
                    check_val("wr_extra", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("wr_data", 64'(s_data), 64'(e));
                    check_val("wr_gnt", 64'(s_gnt), 64'd1 << e[31:24]);
                end
                if (last_id >= 0 && id != last_id) check_val("bubble", 64'(gap), 64'd1);
            end
            last_id = id;
            gap = 0;
        end else begin
            gap++;
        end
        if (mode == 2) begin
            rd = drain || ($urandom_range(0, 1) == 0);
            if (fifo_full) begin
                stall_seen++;
                check_val("full_no_wr", 64'(s_en), 64'd0);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (s_ack[i]) begin
                rem[i]--;
                seq[i]++;
            end
        end
        if (mode == 2) begin
            if (rd && mq.size() > 0) begin
                got = mq.pop_front();
                if (exp_q.size() == 0) begin
                    check_val("rd_extra", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("rd_order", 64'(got), 64'(e));
                end
            end
            if (s_en) mq.push_back(s_data);
            fifo_full = (mq.size() >= FDEPTH);
        end
        drive_req();
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int c;
        c = 0;
        while (n_wr < target && c < budget) begin
            step();
            c++;
        end
        check_val(tag, 64'(n_wr), 64'(target));
    endtask

    initial begin
        // Test 1: reset values, idle, asynchronous reset mid-cycle
        do_reset();
        check_val("rst_gnt", 64'(gnt), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_wen", 64'(fifo_w_en), 64'd0);
        check_val("rst_stall", 64'(stall_cnt), 64'd0);
        mode = 0;
        repeat (10) begin
            step();
            check_val("idle_gnt", 64'(s_gnt), 64'd0);
            check_val("idle_wen", 64'(s_en), 64'd0);
            check_val("idle_busy", 64'(s_busy), 64'd0);
        end
        rem[0] = 100;
        drive_req();
        step();
        step();
        check_val("pre_rst_busy", 64'(busy), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_gnt", 64'(gnt), 64'd0);
        check_val("arst_busy", 64'(busy), 64'd0);
        check_val("arst_wen", 64'(fifo_w_en), 64'd0);
        check_val("arst_ack", 64'(ack), 64'd0);
        check_val("arst_wdata", 64'(fifo_wdata), 64'd0);

        // Test 2: all requesting, grants 0,1,2,3,0 with full bursts
        do_reset();
        mode = 1;
        for (int g = 0; g < 5; g++) push_burst(g % N_REQ, (g / N_REQ) * MAX_BURST, MAX_BURST);
        for (int i = 0; i < N_REQ; i++) rem[i] = 100;
        drive_req();
        run_until(5 * MAX_BURST, 200, "t2_writes");
        for (int i = 0; i < N_REQ; i++) rem[i] = 0;
        drive_req();
        step();
        check_val("t2_busy_end", 64'(busy), 64'd0);
        check_val("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // Test 3: single requester drops after 3 words
        do_reset();
        push_burst(2, 0, 3);
        rem[2] = 3;
        drive_req();
        run_until(3, 50, "t3_writes");
        step();
        check_val("t3_gnt_hold", 64'(s_gnt), 64'b0100);
        check_val("t3_no_wr", 64'(s_en), 64'd0);
        step();
        check_val("t3_gnt_rel", 64'(s_gnt), 64'd0);
        check_val("t3_busy_rel", 64'(s_busy), 64'd0);
        check_val("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Test 4: owner 1 stalled by fifo_full for 5 cycles after 2 writes
        do_reset();
        push_burst(1, 0, MAX_BURST);
        rem[1] = MAX_BURST;
        drive_req();
        run_until(2, 50, "t4_pre");
        fifo_full = 1'b1;
        repeat (5) begin
            step();
            check_val("t4_stall_ack", 64'(s_ack), 64'd0);
            check_val("t4_stall_gnt", 64'(s_gnt), 64'b0010);
        end
        fifo_full = 1'b0;
        check_val("t4_stall_cnt", 64'(stall_cnt), 64'(STALL_EXP));
        run_until(MAX_BURST, 50, "t4_post");
        step();
        check_val("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // Test 5: last owner 3, req 0101: 0 wins, then 2, then 0 again
        do_reset();
        push_burst(0, 0, MAX_BURST);
        push_burst(2, 0, MAX_BURST);
        push_burst(0, MAX_BURST, 2);
        rem[0] = MAX_BURST + 2;
        rem[2] = MAX_BURST;
        drive_req();
        run_until(2 * MAX_BURST + 2, 100, "t5_writes");
        step();
        check_val("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // Test 6: 1024 words through a modelled FIFO with random draining
        do_reset();
        mode = 2;
        stall_seen = 0;
        for (int b = 0; b < 256 / MAX_BURST; b++)
            for (int r = 0; r < N_REQ; r++) push_burst(r, b * MAX_BURST, MAX_BURST);
        for (int i = 0; i < N_REQ; i++) rem[i] = 256;
        drive_req();
        run_until(1024, 20000, "t6_writes");
        drain = 1'b1;
        for (int c = 0; c < 100 && mq.size() > 0; c++) step();
        check_val("t6_q_empty", 64'(exp_q.size()), 64'd0);
        check_val("t6_fifo_empty", 64'(mq.size()), 64'd0);
        check_val("t6_full_seen", 64'(stall_seen > 0), 64'd1);
        mode = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin burst arbiter that shares the single write port of the 32-bit sync FIFO between N_REQ producers. Each producer holds a request with its data word. The arbiter grants one producer at a time for a burst of up to MAX_BURST accepted words, stalls the winner on fifo full, and forwards the winner's data onto the FIFO write port. It sits directly upstream of the FIFO; its write-port outputs connect straight to the FIFO's w_en and data_in.

Parameters:
N_REQ, 4, number of requesters (2..16)
DW, 32, data word width; matches FIFO data width
MAX_BURST, 8, max words accepted per grant (1..256)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester request/valid; bit i high means data_in slice i holds a word to write
data_in  input  N_REQ*DW  packed data; slice i = bits [i*DW +: DW]
fifo_full  input  1  FIFO full flag
gnt  output  N_REQ  registered one-hot owner of the write port; all-zero when idle
ack  output  N_REQ  combinational; bit i high means requester i's word is written at this rising edge
fifo_w_en  output  1  combinational FIFO write enable, equal to OR of ack
fifo_wdata  output  DW  combinational mux of the owner's data slice; 0 when no owner
busy  output  1  registered; high while state is BURST
stall_cnt  output  16  stall statistics counter (see Optional Feature)

Behaviour:
- State register: IDLE, BURST. Also registered: owner index, last-owner index, burst count (width clog2(MAX_BURST)+1).
- Reset (async, immediate): state=IDLE; gnt=0; busy=0; count=0; last-owner=N_REQ-1, so requester 0 has first priority; stall_cnt=0.
- Combinational outputs under reset: ack=0, fifo_w_en=0, fifo_wdata=0.
- IDLE, no req bit set: stay in IDLE.
- IDLE, req!=0: pick the first set bit scanning from last-owner+1 upward, wrapping modulo N_REQ.
  - Next edge: state=BURST, gnt=onehot(winner), busy=1, count=0.
  - No word is written in the arbitration cycle.
- BURST, ack[owner] = req[owner] & ~fifo_full; all other ack bits are 0.
- BURST, acceptance: on each acked edge, count+1.
- BURST, release at an edge (state=IDLE, gnt=0, busy=0, last-owner=owner) when either:
  - an ack takes count to MAX_BURST, or
  - req[owner]=0 during the cycle.
- Latency: req rises in IDLE in cycle t; earliest ack is in cycle t+1; one idle bubble between consecutive grants.
- fifo_full during BURST: ack=0, count holds, ownership retained (stall, no release). Writes resume the cycle full deasserts.
- Requests from non-owners during BURST are ignored. They are served in round-robin order after release.
- Single requester repeatedly requesting: it re-wins after each bubble. The pattern is MAX_BURST writes, 1 bubble, and so on.
- MAX_BURST=1: every grant ends after one accepted word.
- fifo_wdata follows the owner slice even when ack=0. It is only meaningful when fifo_w_en=1.
- Requesters must hold data stable while req is high and ack is low. Dropping req without ack is legal: that word is never written.

Optional Feature:
Macro FIFO_WR_ARB_STATS_EN.
- Defined: stall_cnt increments at each edge where state=BURST, req[owner]=1 and fifo_full=1. It saturates at 16'hFFFF and is cleared only by rst.
- Undefined: no counter logic; stall_cnt is tied to 16'h0000. Arbitration behaviour is identical in both builds.

Test Plan:
1. Reset then req=4'b0000 for 10 cycles -> gnt=0, fifo_w_en=0, busy=0 throughout. Assert rst mid-cycle -> outputs 0 immediately.
2. req=4'b1111 held, fifo_full=0, MAX_BURST=8 -> grants in order 0,1,2,3,0. Each grant gives exactly 8 writes with data from the matching slice, separated by 1 idle cycle.
3. req[2] only, drop req[2] after 3 acks -> exactly 3 writes, release at the drop cycle, gnt returns to 0 next edge.
4. Owner=1 after 2 writes, fifo_full=1 for 5 cycles -> ack=0 and gnt=4'b0010 held for 5 cycles, then 6 more writes. With FIFO_WR_ARB_STATS_EN, stall_cnt=5.
5. Last owner=3, then req=4'b0101 -> requester 0 wins. After its release, requester 2 wins, not 0.
6. Drive the real FIFO with 1024 words from 4 requesters (256 each) -> FIFO full asserts and the arbiter stalls. Drain via r_en: read-out order matches the grant order and no word is lost or duplicated.
